// File: rtl/dual_port_sync_ram_if.sv
// rtl/dual_port_sync_ram_if.sv - bus bundle for dual_port_sync_ram
// Purpose: groups the clear, write, and read signals of the RAM.
// Signals:
//   clr/busy                    clear request and sweep-in-progress flag
//   we/waddr/wdata/wbe          byte-enabled write port
//   re/raddr/rdata/rvalid       read port with registered data and valid flag
// Modports: master drives requests, slave is the RAM.
interface dual_port_sync_ram_if #(
    parameter int WIDTH    = 16,
    parameter int ADDR_BUS = 3
);
    logic                  clr;
    logic                  busy;
    logic                  we;
    logic [ADDR_BUS-1:0]   waddr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wbe;
    logic                  re;
    logic [ADDR_BUS-1:0]   raddr;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;

    modport master (
        output clr, we, waddr, wdata, wbe, re, raddr,
        input  busy, rdata, rvalid
    );

    modport slave (
        input  clr, we, waddr, wdata, wbe, re, raddr,
        output busy, rdata, rvalid
    );
endinterface

// File: rtl/dual_port_sync_ram.sv
// rtl/dual_port_sync_ram.sv - simple-dual-port synchronous RAM with clear sweep
// Purpose: one byte-enabled write port and one registered read port on a single
//   clock. After reset, or on a clr pulse, a sweep writes zero to every word.
// Ports:
//   clk   clock; all state changes happen on the rising edge
//   rst   asynchronous active-low reset
//   bus   dual_port_sync_ram_if.slave (clr/busy, we/waddr/wdata/wbe,
//         re/raddr/rdata/rvalid)
// Parameters: WIDTH (a multiple of 8), DEPTH (1..2^ADDR_BUS), ADDR_BUS.
// Configuration macro: WRITE_FIRST_EN. When it is defined, a read that hits the
//   address being written in the same cycle returns the merged new word. When it
//   is undefined, the read is read-first and returns the old word.
module dual_port_sync_ram #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_BUS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_port_sync_ram_if.slave   bus
);
    localparam int                NB      = WIDTH / 8;
    localparam logic [ADDR_BUS:0] DEPTH_W = (ADDR_BUS + 1)'(DEPTH);
    localparam logic [ADDR_BUS-1:0] LAST  = ADDR_BUS'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state;
    logic [ADDR_BUS-1:0]  cnt;
    logic                 busy_q;
    logic [WIDTH-1:0]     rdata_q;
    logic                 rvalid_q;
    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 idle;
    logic                 waddr_ok;
    logic                 raddr_ok;
    logic                 wr_en;
    logic [WIDTH-1:0]     rd_word;

    assign idle     = (state == IDLE);
    // Extend by one bit so that DEPTH == 2^ADDR_BUS compares correctly.
    assign waddr_ok = ({1'b0, bus.waddr} < DEPTH_W);
    assign raddr_ok = ({1'b0, bus.raddr} < DEPTH_W);
    // A clr accepted in this cycle takes priority and drops the write.
    assign wr_en    = idle && bus.we && !bus.clr && waddr_ok;

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[bus.raddr];
`ifdef WRITE_FIRST_EN
            if (wr_en && (bus.waddr == bus.raddr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.wbe[i]) begin
                        rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
                    end
                end
            end
`endif
        end
    end

    // The array has no reset. It is zeroed by the sweep, one word per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rvalid_q <= 1'b0;
                    if (cnt == LAST) begin
                        // busy falls on the same edge as the final sweep write.
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clr) begin
                        state  <= CLEAR;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                    // A read issued in the same cycle as clr is still served.
                    rvalid_q <= bus.re;
                    if (bus.re) begin
                        rdata_q <= rd_word;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_q <= 1'b1;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: doc/dual_port_sync_ram.md
# dual_port_sync_ram

Parametrised simple-dual-port synchronous RAM with one write port (byte-enabled) and one read port, both on a single clock. It is the next generation of the team's single-port 8x16 RAM: it splits the shared bidirectional data bus into dedicated write and read paths, and registers read data with a valid flag. It also provides a hardware clear sweep that zeroes the array after reset or on request. It is intended as the generic storage primitive for buffers and register files.

## Interface
- WIDTH, 16, data word width in bits; must be a multiple of 8
- DEPTH, 8, number of words; 1 ≤ DEPTH ≤ 2^ADDR_BUS
- ADDR_BUS, 3, address width in bits
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  request a clear sweep; single-cycle pulse, sampled when idle
- busy  output  1  high while the clear sweep runs
- we  input  1  write enable
- waddr  input  ADDR_BUS  write address
- wdata  input  WIDTH  write data
- wbe  input  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- re  input  1  read enable
- raddr  input  ADDR_BUS  read address
- rdata  output  WIDTH  registered read data
- rvalid  output  1  rdata updated this cycle

## Operation
- FSM has two states: CLEAR and IDLE. The sweep counter is ADDR_BUS bits wide.
- Reset (rst=0), applied asynchronously:
  - state=CLEAR, counter=0, busy=1, rdata=0, rvalid=0.
  - Array contents are not reset directly; they are zeroed by the sweep.
- CLEAR state:
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - After the write to DEPTH-1: state becomes IDLE and busy falls on that same edge.
  - The sweep takes exactly DEPTH cycles.
- IDLE state:
  - clr=1 sets state=CLEAR, counter=0 and busy=1 on the next edge.
  - A we asserted in the same cycle as clr is dropped. A re asserted in that cycle is still served.
- While busy=1: we, re and clr are ignored and rvalid stays 0.
- Write: we=1 in IDLE sets mem[waddr] byte i to wdata byte i for every wbe[i]=1. Other bytes are unchanged. wbe=0 makes the write a no-op.
- Read: re=1 in IDLE sets rdata=mem[raddr] and rvalid=1 on the next edge.
  - When re=0: rvalid=0 and rdata holds its last value.
- Out-of-range addresses (≥ DEPTH):
  - A write has no effect.
  - A read returns rdata=0 with rvalid=1.
- Simultaneous read and write to the same address: governed by the macro in Configuration.
- Simultaneous read and write to different addresses: both complete independently.

## Timing
- Read latency is 1 cycle from re to rdata/rvalid. Throughput is one read and one write per cycle.
- A write is visible to a read issued in the following cycle.
- busy is 1 for exactly DEPTH cycles after rst deasserts (first clk edge counts as sweep cycle 0), and for DEPTH cycles after an accepted clr.
- Reset asserted mid-sweep or mid-read:
  - Outputs return to their reset values immediately.
  - The sweep restarts from address 0 after release.
- Counter wrap: with DEPTH = 2^ADDR_BUS the counter wraps to 0 on the final sweep write. No extra cycle is added.

## Configuration
- WRITE_FIRST_EN defined: a same-address read during a write returns the new word. Enabled bytes come from wdata; disabled bytes come from the old contents.
- WRITE_FIRST_EN undefined: read-first. A same-address read returns the word as it was before the write; the new data is visible from the next read.
- The macro affects only same-cycle same-address collisions. All other behaviour is identical.

## Test plan
- Reset then release: busy=1 for 8 cycles, then 0. Reading addresses 0..7 returns 16'h0000 each with rvalid=1, one cycle after each re.
- Write 16'hA465 to addr 5 with wbe=2'b11, then read addr 5: rdata=16'hA465 and rvalid=1 on the cycle after re. Then write 16'hFF00 with wbe=2'b01 and read again: rdata=16'hA400.
- Same-cycle write 16'h1234 and read, both at addr 2 with old value 16'h0000: rdata=16'h1234 with WRITE_FIRST_EN, 16'h0000 without. The next read of addr 2 returns 16'h1234 in both builds.
- DEPTH=6, ADDR_BUS=3: write 16'hBEEF to addr 7, then read addr 7 and addr 0. Both reads give rdata=0 and rvalid=1, and no in-range word is corrupted.
- Fill addrs 0..7 with 16'h1111, pulse clr together with we (addr 3, 16'h2222): the write is dropped, busy=1 for 8 cycles, and re during busy gives rvalid=0. Afterwards every address reads 0.
- Assert rst at sweep cycle 3: busy stays 1, rdata=0 and rvalid=0 immediately. After release busy stays 1 for a full 8 cycles.
